bellek_yanitlayici: RTL and testbench

// - Line-wide RAM responder: the memory end of the ram_* read/write interface that matrix_carpici-class initiators drive.
// - Serves one line-aligned read or write at a time from an internal DERINLIK x VO_VERI_BIT array.
// - Returns read data with its line-aligned byte address after a programmable latency.
// - Reports busy (ram_mesgul_c) while an access is in flight.

---
 rtl/bellek_yanitlayici.sv | 162 ++++++++++++++++
 tb/tb_bellek_yanitlayici.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bellek_yanitlayici.sv
// Line-wide RAM responder: serves one line-aligned read or write at a time from an internal array.
// Optional RAM_HATA_EN adds ram_hata_c, zeroes out-of-range reads and discards out-of-range writes.
module bellek_yanitlayici #(
    parameter int ADRES_BIT    = 32,
    parameter int VO_VERI_BIT  = 1024,
    parameter int SATIR_KAYDIR = 7,
    parameter int DERINLIK     = 256,
    parameter int OKU_GECIKME  = 4,
    parameter int YAZ_GECIKME  = 2
) (
    input  logic                   clk_g,
    input  logic                   resetn,
    input  logic [ADRES_BIT-1:0]   ram_adres_g,
    input  logic                   ram_oku_gecerli_g,
    input  logic [VO_VERI_BIT-1:0] ram_yaz_veri_g,
    input  logic                   ram_yaz_gecerli_g,
    output logic [VO_VERI_BIT-1:0] ram_oku_veri_c,
    output logic [ADRES_BIT-1:0]   ram_oku_adres_c,
    output logic                   ram_oku_gecerli_c,
    output logic                   ram_mesgul_c
`ifdef RAM_HATA_EN
    ,
    output logic                   ram_hata_c
`endif
);

    localparam int SATIR_BIT    = $clog2(DERINLIK);
    localparam int TAM_BIT      = ADRES_BIT - SATIR_KAYDIR;
    localparam int GECIKME_MAKS = (OKU_GECIKME > YAZ_GECIKME) ? OKU_GECIKME : YAZ_GECIKME;
    localparam int SAYAC_BIT    = $clog2(GECIKME_MAKS) + 1;

    typedef enum logic [1:0] {
        BOS = 2'd0,
        OKU = 2'd1,
        YAZ = 2'd2
    } durum_t;

    durum_t                 r_durum, w_durum_next;
    logic [SAYAC_BIT-1:0]   r_sayac, w_sayac_next;
    logic [VO_VERI_BIT-1:0] r_bellek [DERINLIK];
    logic [SATIR_BIT-1:0]   r_satir;
    logic [ADRES_BIT-1:0]   r_adres_hizali;
    logic [VO_VERI_BIT-1:0] r_oku_veri;
    logic [ADRES_BIT-1:0]   r_oku_adres;
    logic                   r_oku_gecerli;
    logic                   r_mesgul;

    logic [TAM_BIT-1:0]     w_tam_satir;
    logic [SATIR_BIT-1:0]   w_satir;
    logic [ADRES_BIT-1:0]   w_adres_hizali;
    logic                   w_bos;
    logic                   w_yaz_kabul;
    logic                   w_oku_kabul;
    logic                   w_oku_bitti;
    logic                   w_yaz_izin;
    logic                   w_unused_ofset;

    assign w_tam_satir    = ram_adres_g[ADRES_BIT-1:SATIR_KAYDIR];
    assign w_satir        = ram_adres_g[SATIR_KAYDIR +: SATIR_BIT];
    assign w_adres_hizali = {w_tam_satir, {SATIR_KAYDIR{1'b0}}};
    assign w_unused_ofset = ^ram_adres_g[SATIR_KAYDIR-1:0];
    assign w_bos          = (r_durum == BOS);
    // Write has priority when both strobes arrive together.
    assign w_yaz_kabul    = w_bos && ram_yaz_gecerli_g;
    assign w_oku_kabul    = w_bos && ram_oku_gecerli_g && !ram_yaz_gecerli_g;
    assign w_oku_bitti    = (r_durum == OKU) && (r_sayac == '0);

`ifdef RAM_HATA_EN
    logic w_aralik_disi;
    logic r_aralik_disi;
    logic r_hata;

    assign w_aralik_disi = (w_tam_satir >= TAM_BIT'(DERINLIK));
    assign w_yaz_izin    = w_yaz_kabul && !w_aralik_disi;
    assign ram_hata_c    = r_hata;

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_aralik_disi <= 1'b0;
            r_hata        <= 1'b0;
        end else begin
            if (w_oku_kabul)
                r_aralik_disi <= w_aralik_disi;
            r_hata <= (!w_bos && (ram_oku_gecerli_g || ram_yaz_gecerli_g))
                   || (w_bos && ram_oku_gecerli_g && ram_yaz_gecerli_g)
                   || (w_bos && (ram_oku_gecerli_g || ram_yaz_gecerli_g) && w_aralik_disi);
        end
    end
`else
    assign w_yaz_izin = w_yaz_kabul;
`endif

    always_ff @(posedge clk_g) begin
        if (resetn && w_yaz_izin)
            r_bellek[w_satir] <= ram_yaz_veri_g;
    end

    // Registered array read; the output register doubles as the held response data.
    always_ff @(posedge clk_g) begin
        if (!resetn)
            r_oku_veri <= '0;
`ifdef RAM_HATA_EN
        else if (w_oku_bitti)
            r_oku_veri <= r_aralik_disi ? '0 : r_bellek[r_satir];
`else
        else if (w_oku_bitti)
            r_oku_veri <= r_bellek[r_satir];
`endif
    end

    always_ff @(posedge clk_g) begin
        if (!resetn) begin
            r_durum        <= BOS;
            r_sayac        <= '0;
            r_satir        <= '0;
            r_adres_hizali <= '0;
            r_oku_adres    <= '0;
            r_oku_gecerli  <= 1'b0;
            r_mesgul       <= 1'b0;
        end else begin
            r_durum       <= w_durum_next;
            r_sayac       <= w_sayac_next;
            r_oku_gecerli <= w_oku_bitti;
            r_mesgul      <= (w_durum_next != BOS);
            if (w_oku_kabul) begin
                r_satir        <= w_satir;
                r_adres_hizali <= w_adres_hizali;
            end
            if (w_oku_bitti)
                r_oku_adres <= r_adres_hizali;
        end
    end

    always_comb begin
        w_durum_next = r_durum;
        w_sayac_next = r_sayac;
        case (r_durum)
            BOS: begin
                if (w_yaz_kabul) begin
                    w_durum_next = YAZ;
                    w_sayac_next = SAYAC_BIT'(YAZ_GECIKME - 1);
                end else if (w_oku_kabul) begin
                    w_durum_next = OKU;
                    w_sayac_next = SAYAC_BIT'(OKU_GECIKME - 1);
                end
            end
            OKU, YAZ: begin
                if (r_sayac == '0)
                    w_durum_next = BOS;
                else
                    w_sayac_next = r_sayac - 1'b1;
            end
            default: w_durum_next = BOS;
        endcase
    end

    assign ram_oku_veri_c    = r_oku_veri;
    assign ram_oku_adres_c   = r_oku_adres;
    assign ram_oku_gecerli_c = r_oku_gecerli;
    assign ram_mesgul_c      = r_mesgul;

endmodule

// File: tb/tb_bellek_yanitlayici.sv
// Directed plus randomized bench for bellek_yanitlayici against a line-array reference model.
// Build with RAM_HATA_EN defined to also exercise the error port.
module tb_bellek_yanitlayici;

    localparam int OG  = 4;
    localparam int YG  = 2;
    localparam int DER = 256;

    logic          clk_g = 1'b0;
    logic          resetn;
    logic [31:0]   ram_adres_g;
    logic          ram_oku_gecerli_g;
    logic [1023:0] ram_yaz_veri_g;
    logic          ram_yaz_gecerli_g;
    logic [1023:0] ram_oku_veri_c;
    logic [31:0]   ram_oku_adres_c;
    logic          ram_oku_gecerli_c;
    logic          ram_mesgul_c;
`ifdef RAM_HATA_EN
    logic          ram_hata_c;
`endif

    bellek_yanitlayici #(
        .ADRES_BIT(32), .VO_VERI_BIT(1024), .SATIR_KAYDIR(7),
        .DERINLIK(DER), .OKU_GECIKME(OG), .YAZ_GECIKME(YG)
    ) dut (
        .clk_g             (clk_g),
        .resetn            (resetn),
        .ram_adres_g       (ram_adres_g),
        .ram_oku_gecerli_g (ram_oku_gecerli_g),
        .ram_yaz_veri_g    (ram_yaz_veri_g),
        .ram_yaz_gecerli_g (ram_yaz_gecerli_g),
        .ram_oku_veri_c    (ram_oku_veri_c),
        .ram_oku_adres_c   (ram_oku_adres_c),
        .ram_oku_gecerli_c (ram_oku_gecerli_c),
        .ram_mesgul_c      (ram_mesgul_c)
`ifdef RAM_HATA_EN
        ,
        .ram_hata_c        (ram_hata_c)
`endif
    );

    always #5 clk_g = ~clk_g;

    logic [1023:0] model [DER];
    int hata_say    = 0;
    int kontrol_say = 0;
    int hata_darbe  = 0;

    task automatic adim();
        @(posedge clk_g);
        #1;
`ifdef RAM_HATA_EN
        if (ram_hata_c === 1'b1) hata_darbe++;
`endif
    endtask

    task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
        kontrol_say++;
        assert (gozlenen === beklenen) else begin
            hata_say++;
            $error("FAIL %s gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic kontrol_veri(input string etiket, input logic [1023:0] gozlenen, input logic [1023:0] beklenen);
        kontrol_say++;
        assert (gozlenen === beklenen) else begin
            hata_say++;
            $error("FAIL %s gozlenen(alt128)=%h beklenen(alt128)=%h", etiket, gozlenen[127:0], beklenen[127:0]);
        end
    endtask

    function automatic logic [1023:0] rastgele_veri();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit aralik_disi(input logic [31:0] adr);
        return (adr >> 7) >= DER;
    endfunction

    task automatic yaz_islem(input logic [31:0] adr, input logic [1023:0] veri, input bit oku_da);
        int beklenen_hata;
        hata_darbe = 0;
        ram_adres_g = adr; ram_yaz_veri_g = veri;
        ram_yaz_gecerli_g = 1'b1; ram_oku_gecerli_g = oku_da;
        adim();
        ram_yaz_gecerli_g = 1'b0; ram_oku_gecerli_g = 1'b0;
`ifdef RAM_HATA_EN
        if (!aralik_disi(adr)) model[(adr >> 7) % DER] = veri;
`else
        model[(adr >> 7) % DER] = veri;
`endif
        kontrol("yaz_mesgul_bas", ram_mesgul_c, 1);
        for (int k = 1; k <= YG; k++) begin
            adim();
            kontrol("yaz_yanit_yok", ram_oku_gecerli_c, 0);
            kontrol("yaz_mesgul", ram_mesgul_c, (k < YG) ? 1 : 0);
        end
        beklenen_hata = (oku_da || aralik_disi(adr)) ? 1 : 0;
`ifdef RAM_HATA_EN
        kontrol("yaz_hata_darbe", hata_darbe, beklenen_hata);
`endif
        $display("yaz adres=%h satir=%0d oku_da=%0d beklenen_hata=%0d", adr, (adr >> 7) % DER, oku_da, beklenen_hata);
    endtask

    task automatic oku_islem(input logic [31:0] adr, input int tekrar, input bit araya_yaz, input logic [1023:0] sahte);
        logic [1023:0] exp_veri;
        logic [31:0]   exp_adres;
        int            beklenen_hata;
        exp_adres = (adr >> 7) << 7;
        exp_veri  = model[(adr >> 7) % DER];
`ifdef RAM_HATA_EN
        if (aralik_disi(adr)) exp_veri = '0;
`endif
        beklenen_hata = (tekrar > 0) ? tekrar : (araya_yaz ? 1 : 0);
        if (aralik_disi(adr)) beklenen_hata++;
        hata_darbe = 0;
        ram_adres_g = adr; ram_oku_gecerli_g = 1'b1; ram_yaz_gecerli_g = 1'b0;
        adim();
        kontrol("oku_mesgul_bas", ram_mesgul_c, 1);
        kontrol("oku_erken_yanit", ram_oku_gecerli_c, 0);
        for (int k = 1; k <= OG; k++) begin
            ram_oku_gecerli_g = (k <= tekrar);
            ram_yaz_gecerli_g = araya_yaz && (k == 1);
            ram_yaz_veri_g    = sahte;
            adim();
            ram_oku_gecerli_g = 1'b0; ram_yaz_gecerli_g = 1'b0;
            if (k < OG) begin
                kontrol("oku_bekle_gecerli", ram_oku_gecerli_c, 0);
                kontrol("oku_bekle_mesgul", ram_mesgul_c, 1);
            end else begin
                kontrol("oku_yanit_gecerli", ram_oku_gecerli_c, 1);
                kontrol("oku_yanit_mesgul", ram_mesgul_c, 0);
                kontrol_veri("oku_veri", ram_oku_veri_c, exp_veri);
                kontrol("oku_adres", ram_oku_adres_c, exp_adres);
            end
        end
        adim();
        kontrol("oku_darbe_tek", ram_oku_gecerli_c, 0);
        kontrol_veri("oku_veri_tut", ram_oku_veri_c, exp_veri);
        kontrol("oku_adres_tut", ram_oku_adres_c, exp_adres);
`ifdef RAM_HATA_EN
        kontrol("oku_hata_darbe", hata_darbe, beklenen_hata);
`endif
        $display("oku adres=%h hizali=%h tekrar=%0d araya_yaz=%0d beklenen_hata=%0d",
                 adr, exp_adres, tekrar, araya_yaz, beklenen_hata);
    endtask

    initial begin
        logic [31:0] adr;
        resetn = 1'b0; ram_adres_g = '0; ram_oku_gecerli_g = 1'b0;
        ram_yaz_veri_g = '0; ram_yaz_gecerli_g = 1'b0;
        adim(); adim();
        kontrol("reset_mesgul", ram_mesgul_c, 0);
        kontrol("reset_gecerli", ram_oku_gecerli_c, 0);
        kontrol_veri("reset_veri", ram_oku_veri_c, '0);
        kontrol("reset_adres", ram_oku_adres_c, 0);
`ifdef RAM_HATA_EN
        kontrol("reset_hata", ram_hata_c, 0);
`endif
        resetn = 1'b1;

        for (int i = 0; i < DER; i++) yaz_islem(32'(i) << 7, rastgele_veri(), 1'b0);

        yaz_islem(32'h80, {128{8'hA5}}, 1'b0);
        oku_islem(32'h80, 0, 1'b0, '0);
        oku_islem(32'h13F, 0, 1'b0, '0);
        oku_islem(32'h80, 2, 1'b0, '0);

        yaz_islem(32'h200, 1024'h1, 1'b1);
        for (int k = 0; k < OG + 1; k++) begin
            adim();
            kontrol("es_zamanli_yanit_yok", ram_oku_gecerli_c, 0);
        end
        oku_islem(32'h200, 0, 1'b0, '0);

        ram_adres_g = 32'h80; ram_oku_gecerli_g = 1'b1;
        adim();
        ram_oku_gecerli_g = 1'b0;
        adim(); adim();
        resetn = 1'b0;
        adim();
        kontrol("kesme_mesgul", ram_mesgul_c, 0);
        kontrol("kesme_gecerli", ram_oku_gecerli_c, 0);
        kontrol_veri("kesme_veri", ram_oku_veri_c, '0);
        resetn = 1'b1;
        for (int k = 0; k < OG + 2; k++) begin
            adim();
            kontrol("kesme_yanit_yok", ram_oku_gecerli_c, 0);
            kontrol("kesme_bos", ram_mesgul_c, 0);
        end
        $display("reset okumayi kesti adres=00000080");

        oku_islem(32'h8000, 0, 1'b0, '0);

        for (int n = 0; n < 60; n++) begin
            adr = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 32767));
            if ($urandom_range(0, 2) == 0)
                yaz_islem(adr, rastgele_veri(), 1'b0);
            else
                oku_islem(adr, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), rastgele_veri());
        end

        $display("Result: errors=%0d of %0d checks", hata_say, kontrol_say);
        $finish;
    end

endmodule
